// File: rtl/bar_chart_renderer.sv
`default_nettype none
// ============================================================================
// Module  : bar_chart_renderer
// Purpose : Draws NUM_BARS run-time sized vertical bars with two highlights;
//           heights/highlights double-buffered and swapped at vblank start.
// Rev     : 1.0
// ============================================================================
module bar_chart_renderer #(
    parameter int          NUM_BARS = 8,
    parameter int          BAR_W    = 64,
    parameter int          BAR_GAP  = 32,
    parameter int          X0       = 32,
    parameter int          BASE_Y   = 570,
    parameter int          HW       = 9,
    parameter int          MAX_H    = 511,
    parameter logic [11:0] COL_BG   = 12'haaa,
    parameter logic [11:0] COL_BAR  = 12'hf00,
    parameter logic [11:0] COL_HL_A = 12'h0f0,
    parameter logic [11:0] COL_HL_B = 12'h00f
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic [10:0]   hcount,
    input  logic [10:0]   vcount,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          hblnk,
    input  logic          vblnk,
    input  logic          wr_en,
    input  logic [3:0]    wr_idx,
    input  logic [HW-1:0] wr_height,
    input  logic          hl_a_en,
    input  logic [3:0]    hl_a_idx,
    input  logic          hl_b_en,
    input  logic [3:0]    hl_b_idx,
    output logic          frame_start,
    output logic [3:0]    r,
    output logic [3:0]    g,
    output logic [3:0]    b,
    output logic          hs,
    output logic          vs
);

    localparam logic [10:0]   X0_V     = 11'(X0);
    localparam logic [10:0]   COL_LAST = 11'(BAR_W + BAR_GAP - 1);
    localparam logic [10:0]   BAR_END  = 11'(BAR_W - 1);
    localparam logic [10:0]   BAR_W_V  = 11'(BAR_W);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_BARS - 1);
    localparam logic [4:0]    NUM_V    = 5'(NUM_BARS);
    localparam logic [HW-1:0] MAX_H_V  = HW'(MAX_H);
    localparam logic [15:0]   BASE_V   = 16'(BASE_Y);

    logic [HW-1:0] shadow_h [16];
    logic [HW-1:0] active_h [16];
    logic          hl_a_on, hl_b_on;
    logic [3:0]    hl_a_sel, hl_b_sel;
    logic          vblnk_d;
    logic          swap;

    assign swap        = vblnk & ~vblnk_d;
    assign frame_start = swap;

    // vblnk_d resets high so a reset released inside vblank waits for a fresh rising edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow_h[i] <= '0;
                active_h[i] <= '0;
            end
            hl_a_on  <= 1'b0;
            hl_b_on  <= 1'b0;
            hl_a_sel <= '0;
            hl_b_sel <= '0;
            vblnk_d  <= 1'b1;
        end else begin
            vblnk_d <= vblnk;
            if (swap) begin
                active_h <= shadow_h;
                hl_a_on  <= hl_a_en;
                hl_a_sel <= hl_a_idx;
                hl_b_on  <= hl_b_en;
                hl_b_sel <= hl_b_idx;
            end
            if (wr_en && ({1'b0, wr_idx} < NUM_V))
                shadow_h[wr_idx] <= (wr_height > MAX_H_V) ? MAX_H_V : wr_height;
        end
    end

    logic [10:0] col_q, col_d;
    logic [3:0]  idx_q, idx_d;
    logic        run_q, run_d;
    logic        in_bar_d;

    always_comb begin
        col_d = col_q;
        idx_d = idx_q;
        run_d = 1'b0;
        if (hcount == X0_V) begin
            col_d = '0;
            idx_d = '0;
            run_d = 1'b1;
        end else if (run_q && !(idx_q == IDX_LAST && col_q == BAR_END)) begin
            run_d = 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                idx_d = idx_q + 4'd1;
            end else begin
                col_d = col_q + 11'd1;
            end
        end
        in_bar_d = run_d && (col_d < BAR_W_V);
    end

    logic [3:0]  s1_idx;
    logic        s1_in_bar;
    logic [10:0] s1_vcount;
    logic        s1_blank, s1_hs, s1_vs;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            idx_q     <= '0;
            run_q     <= 1'b0;
            s1_idx    <= '0;
            s1_in_bar <= 1'b0;
            s1_vcount <= '0;
            s1_blank  <= 1'b1;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
        end else begin
            col_q     <= col_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            s1_idx    <= idx_d;
            s1_in_bar <= in_bar_d;
            s1_vcount <= vcount;
            s1_blank  <= hblnk | vblnk;
            s1_hs     <= hsync;
            s1_vs     <= vsync;
        end
    end

    logic [15:0] bar_h;
    logic        v_hit;
    logic [11:0] pix;

    always_comb begin
        bar_h = 16'(active_h[s1_idx]);
        v_hit = (16'(s1_vcount) < BASE_V) && ((16'(s1_vcount) + bar_h) >= BASE_V);
        pix   = COL_BG;
        if (s1_blank) begin
            pix = 12'h000;
        end else if (s1_in_bar && v_hit) begin
            if (hl_a_on && hl_a_sel == s1_idx)
                pix = COL_HL_A;
            else if (hl_b_on && hl_b_sel == s1_idx)
                pix = COL_HL_B;
            else
                pix = COL_BAR;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b0;
            vs <= 1'b0;
        end else begin
            r  <= pix[11:8];
            g  <= pix[7:4];
            b  <= pix[3:0];
            hs <= s1_hs;
            vs <= s1_vs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bar_chart_renderer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bar_chart_renderer
// Purpose : Scans short raster lines through bar_chart_renderer and compares
//           every output pixel with a geometric reference model.
// Rev     : 1.0
// ============================================================================
module tb_bar_chart_renderer;

    localparam int          NUM_BARS = 8;
    localparam int          BAR_W    = 64;
    localparam int          BAR_GAP  = 32;
    localparam int          X0       = 32;
    localparam int          BASE_Y   = 570;
    localparam int          HW       = 10;
    localparam int          MAX_H    = 511;
    localparam logic [11:0] COL_BG   = 12'haaa;
    localparam logic [11:0] COL_BAR  = 12'hf00;
    localparam logic [11:0] COL_HL_A = 12'h0f0;
    localparam logic [11:0] COL_HL_B = 12'h00f;

    // shortened line timing; the renderer only needs hcount to step by one
    localparam int H_TOT  = 840;
    localparam int H_VIS  = 800;
    localparam int HS_B   = 816;
    localparam int HS_E   = 830;
    localparam int VS_LEN = 100;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b1;
    logic [10:0]   hcount = '0, vcount = '0;
    logic          hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_idx = '0;
    logic [HW-1:0] wr_height = '0;
    logic          hl_a_en = 1'b0, hl_b_en = 1'b0;
    logic [3:0]    hl_a_idx = '0, hl_b_idx = '0;
    logic          frame_start;
    logic [3:0]    r, g, b;
    logic          hs, vs;

    always #5 pclk = ~pclk;

    bar_chart_renderer #(
        .NUM_BARS(NUM_BARS), .BAR_W(BAR_W), .BAR_GAP(BAR_GAP), .X0(X0),
        .BASE_Y(BASE_Y), .HW(HW), .MAX_H(MAX_H), .COL_BG(COL_BG),
        .COL_BAR(COL_BAR), .COL_HL_A(COL_HL_A), .COL_HL_B(COL_HL_B)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_height(wr_height),
        .hl_a_en(hl_a_en), .hl_a_idx(hl_a_idx), .hl_b_en(hl_b_en),
        .hl_b_idx(hl_b_idx), .frame_start(frame_start),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
    );

    int          sh_m [16];
    int          act_m [16];
    bit          ha_en_m, hb_en_m;
    int          ha_idx_m, hb_idx_m;
    bit          prev_vb;
    logic [13:0] exp_d1, exp_d2;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [11:0] ref_px(input int hc, input int vc, input bit blank);
        int left;
        if (blank) return 12'h000;
        for (int k = 0; k < NUM_BARS; k++) begin
            left = X0 + k * (BAR_W + BAR_GAP);
            if (hc >= left && hc < left + BAR_W && vc >= BASE_Y - act_m[k] && vc < BASE_Y) begin
                if (ha_en_m && ha_idx_m == k) return COL_HL_A;
                if (hb_en_m && hb_idx_m == k) return COL_HL_B;
                return COL_BAR;
            end
        end
        return COL_BG;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            sh_m[i]  = 0;
            act_m[i] = 0;
        end
        ha_en_m  = 1'b0;
        hb_en_m  = 1'b0;
        ha_idx_m = 0;
        hb_idx_m = 0;
        prev_vb  = 1'b0;
        exp_d1   = '0;
        exp_d2   = '0;
    endtask

    task automatic step(input int hc, input int vc, input bit hb, input bit vb,
                        input bit hsy, input bit vsy, input bit we, input int widx, input int wh);
        logic [13:0] obs;
        bit          swp;
        @(negedge pclk);
        obs = {r, g, b, hs, vs};
        checks++;
        assert (obs === exp_d2)
        else begin
            failures++;
            $error("FAIL pipe_out hc=%0d vc=%0d obs={rgb,hs,vs}=%h exp=%h", hc, vc, obs, exp_d2);
        end
        hcount    = 11'(hc);
        vcount    = 11'(vc);
        hblnk     = hb;
        vblnk     = vb;
        hsync     = hsy;
        vsync     = vsy;
        wr_en     = we;
        wr_idx    = 4'(widx);
        wr_height = HW'(wh);
        swp = vb && !prev_vb;
        if (swp) begin
            act_m    = sh_m;
            ha_en_m  = hl_a_en;
            ha_idx_m = int'(hl_a_idx);
            hb_en_m  = hl_b_en;
            hb_idx_m = int'(hl_b_idx);
        end
        if (we && int'(wr_idx) < NUM_BARS)
            sh_m[wr_idx] = (int'(wr_height) > MAX_H) ? MAX_H : int'(wr_height);
        prev_vb = vb;
        #1;
        checks++;
        assert (frame_start === swp)
        else begin
            failures++;
            $error("FAIL frame_start hc=%0d obs=%b exp=%b", hc, frame_start, swp);
        end
        exp_d2 = exp_d1;
        exp_d1 = {ref_px(hc, vc, hb || vb), hsy, vsy};
    endtask

    task automatic do_release();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        hcount = '0;
        vcount = '0;
        hblnk  = 1'b1;
        vblnk  = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        wr_en  = 1'b0;
        rst_n  = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert ({r, g, b, hs, vs, frame_start} === 15'h0)
        else begin
            failures++;
            $error("FAIL %s obs={rgb,hs,vs,fs}=%h exp=0000", tag, {r, g, b, hs, vs, frame_start});
        end
    endtask

    task automatic run_line(input int vc, input bit vb, input int wr_at, input int wr_n,
                            input int widx, input int wh, input int rst_at);
        bit we;
        for (int hc = 0; hc < H_TOT; hc++) begin
            we = (hc >= wr_at) && (hc < wr_at + wr_n);
            step(hc, vc, hc >= H_VIS, vb, (hc >= HS_B) && (hc < HS_E), vb && (hc < VS_LEN),
                 we, widx + hc - wr_at, wh);
            if (hc == rst_at) begin
                #1 rst_n = 1'b0;
                #1 check_reset_outputs("mid_line_reset");
                do_release();
                return;
            end
        end
    endtask

    task automatic vblank_line();
        run_line(600, 1'b1, -1, 0, 0, 0, -1);
    endtask

    task automatic vis_line(input int vc);
        run_line(vc, 1'b0, -1, 0, 0, 0, -1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        do_release();

        // all bars 100 high: shadow only until the swap
        run_line(470, 1'b0, 100, 8, 0, 100, -1);
        vblank_line();
        vis_line(470);
        vis_line(569);
        vis_line(469);
        vis_line(570);
        vblank_line();

        // bar 2 = 300 mid-frame must not tear
        run_line(300, 1'b0, 100, 1, 2, 300, -1);
        vis_line(300);
        vblank_line();
        vis_line(300);

        // write colliding with the swap cycle
        run_line(525, 1'b0, 10, 1, 0, 50, -1);
        run_line(600, 1'b1, 0, 1, 0, 80, -1);
        vis_line(525);
        vis_line(500);
        vblank_line();
        vis_line(500);

        // clamp, out-of-range index, zero height
        run_line(400, 1'b0, 10, 1, 1, 600, -1);
        run_line(400, 1'b0, 10, 1, 9, 200, -1);
        run_line(400, 1'b0, 10, 1, 4, 0, -1);
        vblank_line();
        vis_line(59);
        vis_line(58);
        vis_line(569);

        // highlights
        hl_a_en = 1'b1; hl_a_idx = 4'd3;
        hl_b_en = 1'b1; hl_b_idx = 4'd3;
        vblank_line();
        vis_line(569);
        hl_b_idx = 4'd5;
        vis_line(569);
        vblank_line();
        vis_line(569);

        // reset in the middle of a visible line
        run_line(569, 1'b0, -1, 0, 0, 0, 400);
        vis_line(569);
        vblank_line();
        vis_line(569);

        repeat (6) begin
            hl_a_en  = 1'($urandom_range(0, 1));
            hl_a_idx = 4'($urandom_range(0, 15));
            hl_b_en  = 1'($urandom_range(0, 1));
            hl_b_idx = 4'($urandom_range(0, 15));
            vblank_line();
            repeat (3)
                run_line(int'($urandom_range(0, 599)), 1'b0, int'($urandom_range(0, 839)),
                         int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 1023)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
